mips_io_bridge: RTL and testbench

- Address-decoding bridge between the MIPS CPU data port and the memory-mapped peripherals: timer/counter (TC), 32-bit input port (IN32), 32-bit output port (OUT32).
- Splits the processor address into a device ID and an in-device offset.
- Read path: muxes the selected device's read data back to the CPU.
- Write path: broadcasts write data and raises a one-hot write enable.
- Clocked side: registers device interrupt lines and keeps a sticky unmapped-access flag.

---
 rtl/mips_io_bridge.sv | 51 +++++
 tb/tb_mips_io_bridge.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_io_bridge.sv
// mips_io_bridge: address decoder linking the MIPS data port to the TC, IN32 and OUT32 peripherals
module mips_io_bridge #(
  parameter int DEV_COUNT   = 3,
  parameter int DEV_ID_WD   = 2,
  parameter int DEV_ADDR_WD = 8,
  parameter int DEV_TC      = 0,
  parameter int DEV_IN32    = 1,
  parameter int DEV_OUT32   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               PrAddr,
  input  logic [31:0]               PrWD,
  input  logic                      PrWE,
  output logic [31:0]               PrRD,
  output logic [DEV_ADDR_WD:1]      DevAddr,
  output logic [31:0]               DevWD,
  output logic [DEV_COUNT-1:0]      DevWE,
  input  logic [32*DEV_COUNT-1:0]   DevRD,
  input  logic [DEV_COUNT-1:0]      DevIRQ,
  output logic [5:0]                HWInt,
  output logic                      BusErr
);
  localparam int HI_LSB = DEV_ADDR_WD + DEV_ID_WD;
  localparam int POP = (1 << DEV_COUNT) - 1;
  localparam int NAMED = (1 << DEV_TC) | (1 << DEV_IN32) | (1 << DEV_OUT32);
  localparam logic [2**DEV_ID_WD-1:0] LIVE = (2**DEV_ID_WD)'((NAMED | POP) & POP);
  logic [DEV_ID_WD-1:0] devId;
  logic mapped;
  assign devId = PrAddr[HI_LSB-1:DEV_ADDR_WD];
  assign mapped = ~|PrAddr[31:HI_LSB] & LIVE[devId];
  assign DevAddr = PrAddr[DEV_ADDR_WD-1:0];
  assign DevWD = PrWD;
  always_comb begin
    PrRD = '0;
    DevWE = '0;
    for (int i = 0; i < DEV_COUNT; i++) begin
      if (mapped && devId == DEV_ID_WD'(i)) PrRD = DevRD[32*i +: 32];
      DevWE[i] = PrWE & mapped & (devId == DEV_ID_WD'(i));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HWInt <= '0;
      BusErr <= 1'b0;
    end else begin
      HWInt <= 6'(DevIRQ);
      BusErr <= BusErr | ~mapped;
    end
  end
endmodule

// File: tb/tb_mips_io_bridge.sv
// tb_mips_io_bridge: directed plus randomized checks of mips_io_bridge against an address-map model
module tb_mips_io_bridge;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] PrAddr, PrWD, PrRD, DevWD;
  logic PrWE;
  logic [8:1] DevAddr;
  logic [2:0] DevWE, DevIRQ;
  logic [95:0] DevRD;
  logic [5:0] HWInt;
  logic BusErr;
  logic [31:0] dev [3];
  int tests = 0;
  int fails = 0;
  logic [5:0] mHw;
  bit mBus;

  mips_io_bridge dut (
    .clk(clk), .rst_n(rst_n), .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE),
    .PrRD(PrRD), .DevAddr(DevAddr), .DevWD(DevWD), .DevWE(DevWE),
    .DevRD(DevRD), .DevIRQ(DevIRQ), .HWInt(HWInt), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  function automatic bit isMapped(logic [31:0] a);
    return (a >> 10) == 0 && ((a >> 8) & 3) < 3;
  endfunction

  function automatic logic [31:0] expRd(logic [31:0] a);
    return isMapped(a) ? dev[(a >> 8) & 3] : 32'h0;
  endfunction

  function automatic logic [2:0] expWe(logic [31:0] a, logic we);
    return (we && isMapped(a)) ? 3'(1 << ((a >> 8) & 3)) : 3'b000;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setDev(logic [31:0] a0, logic [31:0] a1, logic [31:0] a2);
    dev[0] = a0; dev[1] = a1; dev[2] = a2;
    DevRD = {a2, a1, a0};
  endtask

  task automatic comb(string tag);
    #1;
    chk({tag, ".rd"}, PrRD, expRd(PrAddr));
    chk({tag, ".addr"}, 32'(DevAddr), PrAddr & 32'hff);
    chk({tag, ".wd"}, DevWD, PrWD);
    chk({tag, ".we"}, 32'(DevWE), 32'(expWe(PrAddr, PrWE)));
  endtask

  task automatic tick(string tag);
    if (rst_n) begin
      mHw = 6'(DevIRQ);
      mBus = mBus | !isMapped(PrAddr);
    end
    @(posedge clk);
    #1;
    chk({tag, ".hw"}, 32'(HWInt), 32'(mHw));
    chk({tag, ".buserr"}, 32'(BusErr), 32'(mBus));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    mHw = '0;
    mBus = 1'b0;
    #1;
    chk("rst.hw", 32'(HWInt), 32'h0);
    chk("rst.buserr", 32'(BusErr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    PrAddr = 32'h0; PrWD = 32'h0; PrWE = 1'b0; DevIRQ = 3'b000;
    mHw = '0; mBus = 1'b0;
    setDev(32'h1234_5678, 32'h8765_fedc, 32'h89ab_cdef);
    #12;
    chk("reset.hw", 32'(HWInt), 32'h0);
    chk("reset.buserr", 32'(BusErr), 32'h0);
    PrAddr = 32'h0000_0045;
    comb("reset.comb");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    PrAddr = 32'h045; #1;
    chk("rd.tc", PrRD, 32'h1234_5678);
    chk("rd.tc.addr", 32'(DevAddr), 32'h45);
    chk("rd.tc.we", 32'(DevWE), 32'h0);
    PrAddr = 32'h167; #1;
    chk("rd.in32", PrRD, 32'h8765_fedc);
    chk("rd.in32.addr", 32'(DevAddr), 32'h67);
    PrAddr = 32'h2df; #1;
    chk("rd.out32", PrRD, 32'h89ab_cdef);
    chk("rd.out32.addr", 32'(DevAddr), 32'hdf);
    tick("rd");

    PrWD = 32'hfedc_4321; PrWE = 1'b1;
    PrAddr = 32'h073; #1;
    chk("wr.tc.wd", DevWD, 32'hfedc_4321);
    chk("wr.tc.addr", 32'(DevAddr), 32'h73);
    chk("wr.tc.we", 32'(DevWE), 32'b001);
    PrAddr = 32'h192; #1;
    chk("wr.in32.we", 32'(DevWE), 32'b010);
    chk("wr.in32.addr", 32'(DevAddr), 32'h92);
    PrAddr = 32'h27e; #1;
    chk("wr.out32.we", 32'(DevWE), 32'b100);
    chk("wr.out32.addr", 32'(DevAddr), 32'h7e);
    tick("wr");
    chk("wr.noerr", 32'(BusErr), 32'h0);

    PrAddr = 32'h310; #1;
    chk("unm.id3.rd", PrRD, 32'h0);
    chk("unm.id3.we", 32'(DevWE), 32'h0);
    tick("unm.id3");
    chk("unm.id3.set", 32'(BusErr), 32'h1);
    PrAddr = 32'h045; PrWE = 1'b0;
    tick("unm.sticky1");
    tick("unm.sticky2");
    chk("unm.sticky", 32'(BusErr), 32'h1);
    pulseReset();
    chk("unm.cleared", 32'(BusErr), 32'h0);
    PrAddr = 32'h0000_0400; PrWE = 1'b1; #1;
    chk("unm.hi.rd", PrRD, 32'h0);
    chk("unm.hi.we", 32'(DevWE), 32'h0);
    tick("unm.hi");
    chk("unm.hi.set", 32'(BusErr), 32'h1);

    PrAddr = 32'h045; PrWE = 1'b0;
    DevIRQ = 3'b101; #1;
    chk("irq.lat", 32'(HWInt), 32'h0);
    tick("irq.on");
    chk("irq.101", 32'(HWInt), 32'b000101);
    DevIRQ = 3'b000;
    tick("irq.off");
    chk("irq.000", 32'(HWInt), 32'h0);

    DevIRQ = 3'b111;
    tick("async.prep");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mHw = '0; mBus = 1'b0;
    #1;
    chk("async.hw", 32'(HWInt), 32'h0);
    chk("async.buserr", 32'(BusErr), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    DevIRQ = 3'b000;

    PrWE = 1'b0; PrAddr = 32'h045; #1;
    chk("rdonly.we", 32'(DevWE), 32'h0);
    chk("rdonly.rd", PrRD, 32'h1234_5678);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 7) a = {22'h0, 2'($urandom_range(0, 2)), 8'($urandom)};
      else if (kind < 9) a = {22'h0, 2'b11, 8'($urandom)};
      else a = $urandom | 32'h0000_0400;
      setDev($urandom, $urandom, $urandom);
      PrAddr = a;
      PrWD = $urandom;
      PrWE = 1'($urandom);
      DevIRQ = 3'($urandom);
      comb("rand");
      tick("rand");
      if (n % 25 == 24) pulseReset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
